ipv4_chksum_stream: RTL and testbench

IPV4_CHKSUM_STREAM -- requirements
Module: ipv4_chksum_stream

---
 rtl/ipv4_pkg.sv | 22 ++
 rtl/ipv4_chksum_stream_if.sv | 27 ++
 rtl/oc_add16.sv | 12 +
 rtl/ipv4_chksum_stream.sv | 145 ++++++++++++++
 tb/tb_ipv4_chksum_stream.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ipv4_pkg.sv
// Shared types and constants for the streaming IPv4 header checksum block.
package ipv4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Halfword position of the header checksum field (bytes 10-11)
  localparam int unsigned CHKSUM_HW_IDX = 5;
  // Smallest legal IHL (20-byte header)
  localparam int unsigned IHL_MIN       = 5;

  // Number of 16-bit halfwords carried by a given number of beats
  function automatic int unsigned halfword_count(input int unsigned data_w,
                                                 input int unsigned beats);
    return beats * (data_w / 16);
  endfunction

endpackage

// File: rtl/ipv4_chksum_stream_if.sv
// Header-in / checksum-out bus of the IPv4 checksum block.
interface ipv4_chksum_stream_if #(
  parameter int unsigned DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              mode;
  logic              m_valid;
  logic              m_ready;
  logic [15:0]       m_chksum;
  logic              m_ok;
  logic              m_err;

  // Traffic source / result sink side
  modport master (
    output s_valid, s_data, s_last, mode, m_ready,
    input  s_ready, m_valid, m_chksum, m_ok, m_err
  );

  // Checksum engine side
  modport slave (
    input  s_valid, s_data, s_last, mode, m_ready,
    output s_ready, m_valid, m_chksum, m_ok, m_err
  );
endinterface

// File: rtl/oc_add16.sv
// End-around-carry fold: low halfword plus everything above it.
module oc_add16 #(
  parameter int unsigned ACC_W = 21
) (
  input  logic [ACC_W-1:0] acc,
  output logic [ACC_W-1:0] sum
);

  // One fold step of a ones'-complement sum
  assign sum = ACC_W'(acc[15:0]) + (acc >> 16);

endmodule

// File: rtl/ipv4_chksum_stream.sv
// Streaming IPv4 header checksum generator / checker.
module ipv4_chksum_stream
  import ipv4_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_WORDS = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  ipv4_chksum_stream_if.slave  bus
);

  localparam int unsigned HPB    = DATA_W / 16;
  localparam int unsigned ACC_W  = 16 + $clog2(MAX_WORDS * HPB);
  localparam int unsigned BEAT_W = $clog2(MAX_WORDS + 1);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_fold;
  logic [ACC_W-1:0]  beat_sum;
  logic [BEAT_W-1:0] beat_cnt;
  logic [3:0]        ihl;
  logic              mode_q;
  logic              ovf;
  logic [1:0]        fold_cnt;
  logic              s_ready;
  logic              m_valid;
  logic [15:0]       m_chksum;
  logic              m_ok;
  logic              m_err;
  logic              accept;
  logic              gen_c;
  logic              len_err_c;
  int unsigned       base_c;

  assign accept = bus.s_valid && s_ready;

  // Mode and halfword base come from the live beat in IDLE, from saved state afterwards
  always_comb begin
    gen_c  = !mode_q;
    base_c = 32'(beat_cnt) * HPB;
    if (state == ST_IDLE) begin
      gen_c  = !bus.mode;
      base_c = 32'd0;
    end
  end

  // Sum the halfwords of the current beat, blanking the checksum field when generating
  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < HPB; i++) begin
      if (!(gen_c && (base_c + i == CHKSUM_HW_IDX))) begin
        beat_sum = beat_sum + ACC_W'(bus.s_data[DATA_W-1-16*i -: 16]);
      end
    end
  end

  // Header length error: bad IHL, too many beats, or halfword count not matching IHL
  assign len_err_c = (ihl < 4'(IHL_MIN)) || ovf ||
                     (halfword_count(DATA_W, 32'(beat_cnt)) != 32'(ihl) * 32'd2);

  oc_add16 #(.ACC_W(ACC_W)) u_fold (
    .acc (acc),
    .sum (acc_fold)
  );

  // Control FSM with accumulator, fold sequencing and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      ihl      <= '0;
      mode_q   <= 1'b0;
      ovf      <= 1'b0;
      fold_cnt <= '0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_chksum <= '0;
      m_ok     <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            mode_q   <= bus.mode;
            ihl      <= bus.s_data[DATA_W-5 -: 4];
            acc      <= beat_sum;
            beat_cnt <= BEAT_W'(1);
            ovf      <= 1'b0;
            fold_cnt <= '0;
            if (bus.s_last) begin
              state   <= ST_FOLD;
              s_ready <= 1'b0;
            end else begin
              state   <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            if (32'(beat_cnt) < MAX_WORDS) begin
              acc      <= acc + beat_sum;
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end else begin
              ovf      <= 1'b1;
            end
            if (bus.s_last) begin
              state   <= ST_FOLD;
              s_ready <= 1'b0;
            end
          end
        end
        ST_FOLD: begin
          if (fold_cnt != 2'd2) begin
            acc      <= acc_fold;
            fold_cnt <= fold_cnt + 2'd1;
          end else begin
            m_chksum <= ~acc[15:0];
            m_err    <= len_err_c;
            m_ok     <= mode_q && !len_err_c && (acc[15:0] == 16'hFFFF);
            m_valid  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = m_valid;
  assign bus.m_chksum = m_chksum;
  assign bus.m_ok     = m_ok;
  assign bus.m_err    = m_err;

endmodule

// File: tb/tb_ipv4_chksum_stream.sv
// Directed bench for ipv4_chksum_stream at 32-, 64- and 16-bit beat widths.
module tb_ipv4_chksum_stream;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] q[$];
  logic [31:0] h [5];

  always #5 clk = ~clk;

  ipv4_chksum_stream_if #(.DATA_W(32)) if32 ();
  ipv4_chksum_stream_if #(.DATA_W(64)) if64 ();
  ipv4_chksum_stream_if #(.DATA_W(16)) if16 ();

  ipv4_chksum_stream #(.DATA_W(32), .MAX_WORDS(15)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  ipv4_chksum_stream #(.DATA_W(64), .MAX_WORDS(15)) dut64 (.clk(clk), .reset(reset), .bus(if64.slave));
  ipv4_chksum_stream #(.DATA_W(16), .MAX_WORDS(30)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));

  // Count one comparison and report it on mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int inst, input logic v, input logic [63:0] d, input logic l, input logic md);
    case (inst)
      16: begin if16.s_valid = v; if16.s_data = d[15:0]; if16.s_last = l; if16.mode = md; end
      64: begin if64.s_valid = v; if64.s_data = d;       if64.s_last = l; if64.mode = md; end
      default: begin if32.s_valid = v; if32.s_data = d[31:0]; if32.s_last = l; if32.mode = md; end
    endcase
  endtask

  task automatic set_mready(input int inst, input logic r);
    case (inst)
      16: if16.m_ready = r;
      64: if64.m_ready = r;
      default: if32.m_ready = r;
    endcase
  endtask

  function automatic logic rdy(input int inst);
    case (inst)
      16: return if16.s_ready;
      64: return if64.s_ready;
      default: return if32.s_ready;
    endcase
  endfunction

  function automatic logic mv(input int inst);
    case (inst)
      16: return if16.m_valid;
      64: return if64.m_valid;
      default: return if32.m_valid;
    endcase
  endfunction

  function automatic logic [17:0] res(input int inst);
    case (inst)
      16: return {if16.m_ok, if16.m_err, if16.m_chksum};
      64: return {if64.m_ok, if64.m_err, if64.m_chksum};
      default: return {if32.m_ok, if32.m_err, if32.m_chksum};
    endcase
  endfunction

  task automatic put(input logic [63:0] w);
    q.push_back(w);
  endtask

  // Push queued beats; mode is inverted after the first beat, gap idle cycles between beats
  task automatic send(input int inst, input logic md, input int gap);
    for (int i = 0; i < q.size(); i++) begin
      int t;
      drive(inst, 1'b1, q[i], i == q.size() - 1, (i == 0) ? md : !md);
      t = 0;
      while (!rdy(inst) && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 40) chk("accept_timeout", 32'(rdy(inst)), 32'd1);
      @(posedge clk); #1;
      if (gap > 0 && i < q.size() - 1) begin
        drive(inst, 1'b0, 64'h0, 1'b0, md);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    drive(inst, 1'b0, 64'h0, 1'b0, 1'b0);
    q.delete();
  endtask

  // Expect m_valid on the 3rd edge after the last beat, hold for 'hold' cycles, then hand off
  task automatic expect_res(input int inst, input string tag, input logic [15:0] e_chk,
                            input logic e_ok, input logic e_err, input int hold);
    logic [17:0] r;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k < 3) chk({tag, "_early"}, 32'(mv(inst)), 32'd0);
    end
    r = res(inst);
    chk({tag, "_valid"}, 32'(mv(inst)), 32'd1);
    chk({tag, "_chksum"}, 32'(r[15:0]), 32'(e_chk));
    chk({tag, "_ok"}, 32'(r[17]), 32'(e_ok));
    chk({tag, "_err"}, 32'(r[16]), 32'(e_err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_out"}, 32'(res(inst)), 32'({e_ok, e_err, e_chk}));
      chk({tag, "_hold_valid"}, 32'(mv(inst)), 32'd1);
      chk({tag, "_hold_sready"}, 32'(rdy(inst)), 32'd0);
    end
    set_mready(inst, 1'b1);
    @(posedge clk); #1;
    set_mready(inst, 1'b0);
    chk({tag, "_drop_valid"}, 32'(mv(inst)), 32'd0);
    chk({tag, "_sready_back"}, 32'(rdy(inst)), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    h[0] = 32'h45000073; h[1] = 32'h00004000; h[2] = 32'h4011B861;
    h[3] = 32'hC0A80001; h[4] = 32'hC0A800C7;
    reset = 1'b1;
    drive(32, 1'b0, 64'h0, 1'b0, 1'b0);
    drive(64, 1'b0, 64'h0, 1'b0, 1'b0);
    drive(16, 1'b0, 64'h0, 1'b0, 1'b0);
    set_mready(32, 1'b0); set_mready(64, 1'b0); set_mready(16, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Reset values
    chk("rst_sready", 32'(rdy(32)), 32'd0);
    chk("rst_mvalid", 32'(mv(32)), 32'd0);
    chk("rst_out", 32'(res(32)), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_sready32", 32'(rdy(32)), 32'd1);
    chk("post_rst_sready64", 32'(rdy(64)), 32'd1);

    // Generate, check and corrupted check at 32 bits
    for (int i = 0; i < 5; i++) put(64'(h[i]));
    send(32, 1'b0, 0);
    expect_res(32, "gen32", 16'hB861, 1'b0, 1'b0, 0);

    for (int i = 0; i < 5; i++) put(64'(h[i]));
    send(32, 1'b1, 0);
    expect_res(32, "chk32", 16'h0000, 1'b1, 1'b0, 0);

    for (int i = 0; i < 5; i++) put((i == 3) ? 64'hC0A80002 : 64'(h[i]));
    send(32, 1'b1, 0);
    expect_res(32, "bad32", 16'hFFFE, 1'b0, 1'b0, 0);

    // Short header: 4 beats with IHL 5
    for (int i = 0; i < 4; i++) put(64'(h[i]));
    send(32, 1'b1, 0);
    expect_res(32, "short32", 16'hC16F, 1'b0, 1'b1, 0);

    // IHL 15 header of exactly 15 beats, with idle gaps between beats
    put(64'h4F000073);
    for (int i = 1; i < 5; i++) put(64'(h[i]));
    for (int i = 5; i < 15; i++) put(64'h0);
    send(32, 1'b0, 2);
    expect_res(32, "ihl15", 16'hAE61, 1'b0, 1'b0, 0);

    // 16th beat is past MAX_WORDS: discarded but flags an error
    put(64'h4F000073);
    for (int i = 1; i < 5; i++) put(64'(h[i]));
    for (int i = 5; i < 15; i++) put(64'h0);
    put(64'hFFFFFFFF);
    send(32, 1'b0, 0);
    expect_res(32, "ovf32", 16'hAE61, 1'b0, 1'b1, 0);

    // Backpressure: m_ready low for 5 cycles
    for (int i = 0; i < 5; i++) put(64'(h[i]));
    send(32, 1'b0, 0);
    expect_res(32, "bp32", 16'hB861, 1'b0, 1'b0, 5);

    // Reset during the third beat
    drive(32, 1'b1, 64'(h[0]), 1'b0, 1'b0); @(posedge clk); #1;
    drive(32, 1'b1, 64'(h[1]), 1'b0, 1'b0); @(posedge clk); #1;
    drive(32, 1'b1, 64'(h[2]), 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sready", 32'(rdy(32)), 32'd0);
    chk("midrst_out", 32'(res(32)), 32'd0);
    reset = 1'b0;
    drive(32, 1'b0, 64'h0, 1'b0, 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (mv(32)) bad = 1'b1;
    end
    chk("midrst_no_valid", 32'(bad), 32'd0);
    chk("midrst_sready_back", 32'(rdy(32)), 32'd1);
    for (int i = 0; i < 5; i++) put(64'(h[i]));
    send(32, 1'b0, 0);
    expect_res(32, "after_rst32", 16'hB861, 1'b0, 1'b0, 0);

    // 64-bit beats: IHL 6 header with four zero option bytes
    put(64'h46000073_00004000); put(64'h4011B861_C0A80001); put(64'hC0A800C7_00000000);
    send(64, 1'b0, 0);
    expect_res(64, "gen64", 16'hB761, 1'b0, 1'b0, 0);
    put(64'h46000073_00004000); put(64'h4011B761_C0A80001); put(64'hC0A800C7_00000000);
    send(64, 1'b1, 0);
    expect_res(64, "chk64", 16'h0000, 1'b1, 1'b0, 0);

    // 16-bit beats
    for (int i = 0; i < 5; i++) begin
      put(64'(h[i][31:16]));
      put(64'(h[i][15:0]));
    end
    send(16, 1'b0, 0);
    expect_res(16, "gen16", 16'hB861, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
